animator_sequencer: RTL and testbench
=====================================

Name: animator_sequencer

Overview:
- Message sequencer that drives segment_animator's charAvailable/charInput pair.
- Holds a small message buffer of 7-segment characters written by the host logic, and plays them back one at a time.
- Issues each character with a clean charAvailable rising edge, then waits a dwell time long enough for the animator to draw every lit segment plus a hold period.
- Optional looping. Shares the same clk60 tick source as the animator.

Parameters:
- DEPTH, 8: message buffer entries; power of 2, minimum 2.
- SEG_TICKS, 16: clk60 ticks of dwell per lit segment (animator steps every 15 ticks, plus 1 margin).
- HOLD_TICKS, 30: extra clk60 ticks after the last segment is drawn.
- PULSE_CYCLES, 2: clk cycles char_available is held high per issue; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global enable; when low, all state, including clk60_prev, is frozen
- clk60  in  1  60 Hz tick level; rising edge detected internally
- wr_en  in  1  append wr_data to buffer
- wr_data  in  7  segment pattern, bit i = segment i
- clear  in  1  empty buffer, abort playback
- start  in  1  begin playback at index 0 (level sampled per cycle)
- loop  in  1  replay from index 0 after last entry (sampled at end of message)
- char_available  out  1  to animator charAvailable
- char_out  out  7  to animator charInput
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a non-looping playback completes
- len  out  $clog2(DEPTH)+1  number of valid buffer entries
- overflow  out  1  sticky; a write was dropped because the buffer was full

Behaviour:
- Reset (async): state=IDLE, len=0, idx=0, char_available=0, char_out=0, busy=0, done=0, overflow=0, dwell counter=0, clk60_prev=0.
- Buffer writes:
  - wr_en with len<DEPTH: buf[len]<=wr_data; len+1.
  - wr_en with len==DEPTH: write dropped; overflow<=1.
  - Writes are legal during playback; appended entries are played if idx has not yet passed them.
- clear has top priority in any state. Same cycle: len<=0, idx<=0, overflow<=0, state<=IDLE, char_available<=0. char_out is held. Any concurrent wr_en or start is ignored.
- clk60 edge: tick = clk60 & ~clk60_prev. clk60_prev updates every enabled cycle.
- FSM:
  - IDLE: if start && len≠0 → ISSUE with idx=0. start with len==0 is ignored.
  - ISSUE: char_out<=buf[idx] on entry and held stable until the next ISSUE. char_available=1 for exactly PULSE_CYCLES cycles. On the last pulse cycle, load dwell = popcount(buf[idx])*SEG_TICKS + HOLD_TICKS → DWELL.
  - DWELL: char_available=0. Decrement dwell on each tick. When dwell reaches 0 (zero at entry counts) → NEXT on the following cycle.
  - NEXT (1 cycle):
    - if idx+1<len: idx+1 → ISSUE;
    - else if loop: idx=0 → ISSUE;
    - else: done=1 for this cycle → IDLE.
- char_available is always low for at least one cycle between consecutive issues, because DWELL and NEXT each last ≥1 cycle. This guarantees a fresh rising edge at the animator.
- Dwell counter is 12 bits; max value 7*SEG_TICKS+HOLD_TICKS must fit, enforced by an elaboration-time check.
- start while busy: ignored. loop change mid-message: takes effect at the next NEXT.
- enable low mid-ISSUE: pulse cycle count freezes. char_available holds its current value.
- After non-loop completion, char_out retains the last character so the display stays stable.

Test Plan:
- Reset mid-DWELL → all outputs 0 within same cycle, len=0, busy=0; after release, start does nothing (len=0).
- Write 0x3F, 0x06; pulse start → char_available high 2 cycles with char_out=0x3F. Dwell=6*16+30=126 ticks. Then 0x06 issued after 2*16+30=62 ticks. done pulses once, busy falls, char_out stays 0x06.
- Write 0x00 with HOLD_TICKS=0 → dwell 0; ISSUE→DWELL→NEXT with no clk60 ticks. char_available low ≥1 cycle between issues.
- loop=1 with 3 entries → sequence idx 0,1,2,0,1 with no done. Drop loop during idx 1 → ends after idx 2 with done.
- Write 9 entries with DEPTH=8 → len=8, overflow=1, 9th discarded. clear → len=0, overflow=0. clear+wr_en same cycle → len=0.
- clk60 held high across the whole dwell → exactly one tick counted. enable=0 for 100 cycles during DWELL with clk60 toggling → dwell unchanged.

Source files
------------

// File: rtl/animator_sequencer.sv
// Message sequencer feeding segment_animator: buffers 7-segment characters and
// issues them one at a time with a clean char_available edge and a per-character dwell.
module animator_sequencer #(
  parameter int DEPTH        = 8,
  parameter int SEG_TICKS    = 16,
  parameter int HOLD_TICKS   = 30,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clk60,
  input  logic                       wr_en,
  input  logic [6:0]                 wr_data,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       loop,
  output logic                       char_available,
  output logic [6:0]                 char_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     len,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = 12;
  localparam int PW = (PULSE_CYCLES < 2) ? 1 : $clog2(PULSE_CYCLES);
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);

  generate
    if (7 * SEG_TICKS + HOLD_TICKS > (1 << DW) - 1) begin : g_dwell_chk
      $error("dwell counter too narrow for 7*SEG_TICKS+HOLD_TICKS");
    end
    if (PULSE_CYCLES < 1) begin : g_pulse_chk
      $error("PULSE_CYCLES must be at least 1");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
      $error("DEPTH must be a power of 2, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DWELL, NEXT} state_t;

  state_t          state, state_nxt;
  logic [6:0]      msg_mem [DEPTH];
  logic [AW-1:0]   idx;
  logic [LW-1:0]   idx_inc;
  logic [DW-1:0]   dwell;
  logic [PW-1:0]   pcnt;
  logic            clk60_prev;
  logic            tick;

  function automatic logic [DW-1:0] dwell_load(input logic [6:0] c);
    logic [DW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 7; i++) cnt = cnt + DW'(c[i]);
    return cnt * DW'(SEG_TICKS) + DW'(HOLD_TICKS);
  endfunction

  assign tick    = clk60 & ~clk60_prev;
  assign idx_inc = {1'b0, idx} + LW'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else if (enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len != '0) state_nxt = ISSUE;
      ISSUE:   if (pcnt == PLAST) state_nxt = DWELL;
      DWELL:   if (dwell == '0) state_nxt = NEXT;
      NEXT:    state_nxt = (idx_inc < len || loop) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Message storage is pure data: no reset, written only on accepted appends.
  always_ff @(posedge clk) begin
    if (enable && !clear && wr_en && len < FULL) msg_mem[len[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len            <= '0;
      idx            <= '0;
      overflow       <= 1'b0;
      char_available <= 1'b0;
      char_out       <= '0;
      done           <= 1'b0;
      dwell          <= '0;
      pcnt           <= '0;
      clk60_prev     <= 1'b0;
    end else if (enable) begin
      clk60_prev <= clk60;
      done       <= 1'b0;
      if (clear) begin
        len            <= '0;
        idx            <= '0;
        overflow       <= 1'b0;
        char_available <= 1'b0;
      end else begin
        if (wr_en) begin
          if (len < FULL) len <= len + LW'(1);
          else overflow <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (start && len != '0) begin
              idx            <= '0;
              char_out       <= msg_mem[0];
              char_available <= 1'b1;
              pcnt           <= '0;
            end
          end
          ISSUE: begin
            if (pcnt == PLAST) begin
              char_available <= 1'b0;
              dwell          <= dwell_load(char_out);
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
          DWELL: begin
            if (dwell != '0 && tick) dwell <= dwell - DW'(1);
          end
          NEXT: begin
            if (idx_inc < len) begin
              idx            <= idx_inc[AW-1:0];
              char_out       <= msg_mem[idx_inc[AW-1:0]];
              char_available <= 1'b1;
              pcnt           <= '0;
            end else if (loop) begin
              idx            <= '0;
              char_out       <= msg_mem[0];
              char_available <= 1'b1;
              pcnt           <= '0;
            end else begin
              done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_animator_sequencer.sv
// Bench for animator_sequencer: plays random and directed messages, counting clk60 ticks
// between issues and comparing against dwell = popcount*SEG_TICKS + HOLD_TICKS.
module tb_animator_sequencer;

  localparam int SEG  = 16;
  localparam int HOLD = 30;
  localparam int PUL  = 2;

  logic       clk = 1'b0;
  logic       reset, enable, clk60, wr_en, clear, start, loop;
  logic [6:0] wr_data;
  logic       char_available, busy, done, overflow;
  logic [6:0] char_out;
  logic [3:0] len;

  logic       z_clk60, z_wr_en, z_clear, z_start;
  logic [6:0] z_wr_data;
  logic       z_ca, z_busy, z_done, z_ovf;
  logic [6:0] z_co;
  logic [1:0] z_len;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  logic ca_q = 1'b0;

  always #5 clk = ~clk;

  animator_sequencer #(.DEPTH(8), .SEG_TICKS(SEG), .HOLD_TICKS(HOLD), .PULSE_CYCLES(PUL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clk60(clk60), .wr_en(wr_en),
    .wr_data(wr_data), .clear(clear), .start(start), .loop(loop),
    .char_available(char_available), .char_out(char_out), .busy(busy), .done(done),
    .len(len), .overflow(overflow));

  animator_sequencer #(.DEPTH(2), .SEG_TICKS(16), .HOLD_TICKS(0), .PULSE_CYCLES(1)) dut_z (
    .clk(clk), .reset(reset), .enable(1'b1), .clk60(z_clk60), .wr_en(z_wr_en),
    .wr_data(z_wr_data), .clear(z_clear), .start(z_start), .loop(1'b0),
    .char_available(z_ca), .char_out(z_co), .busy(z_busy), .done(z_done),
    .len(z_len), .overflow(z_ovf));

  always @(posedge clk) begin
    #1;
    if (char_available && !ca_q) rise_cnt <= rise_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    ca_q <= char_available;
  end

  function automatic int model_dwell(input logic [6:0] c);
    return $countones(c) * SEG + HOLD;
  endfunction

  task automatic wr(input logic [6:0] d);
    @(negedge clk); wr_en = 1'b1; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // mode 0: single-cycle clk60 ticks; 1: clk60 held high first; 2: enable freeze mid-dwell
  task automatic expect_issue(input logic [6:0] exp_c, input int mode);
    int waited, hc, ticks, r0, d0, exp_d;
    bit froze;
    exp_d = model_dwell(exp_c);
    waited = 0;
    while (char_available !== 1'b1 && waited < 60) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (char_available !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout: char_available=%b required 1 for char %h", char_available, exp_c);
      return;
    end
    checks++;
    if (char_out !== exp_c) begin
      errors++;
      $display("FAIL char_out: got %h required %h", char_out, exp_c);
    end
    hc = 0;
    while (char_available === 1'b1 && hc < 20) begin
      @(negedge clk); hc++;
    end
    checks++;
    if (hc != PUL) begin
      errors++;
      $display("FAIL pulse_width: got %0d cycles required %0d", hc, PUL);
    end
    r0 = rise_cnt; d0 = done_cnt; ticks = 0; froze = 0;
    if (mode == 1) begin
      clk60 = 1'b1;
      repeat (40) @(negedge clk);
      clk60 = 1'b0;
      @(negedge clk);
      ticks = 1;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rise_cnt != r0 || done_cnt != d0) break;
      if (mode == 2 && !froze && ticks == 3 && cyc % 4 == 0) begin
        froze = 1;
        enable = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk); clk60 = ~clk60;
        end
        clk60 = 1'b0;
        @(negedge clk);
        checks++;
        if (char_available !== 1'b0 || busy !== 1'b1 || rise_cnt != r0 || done_cnt != d0) begin
          errors++;
          $display("FAIL freeze: ca=%b busy=%b events=%0d required ca=0 busy=1 events=0",
                   char_available, busy, (rise_cnt - r0) + (done_cnt - d0));
        end
        enable = 1'b1;
      end
      clk60 = (cyc % 4 == 0);
      if (cyc % 4 == 0) ticks++;
      @(negedge clk);
    end
    clk60 = 1'b0;
    checks++;
    if (ticks != exp_d) begin
      errors++;
      $display("FAIL dwell_ticks: char %h got %0d ticks required %0d", exp_c, ticks, exp_d);
    end
  endtask

  task automatic check_done_end(input logic [6:0] last_c, input int d0);
    @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1 || busy !== 1'b0 || char_out !== last_c || char_available !== 1'b0) begin
      errors++;
      $display("FAIL end_state: dones=%0d busy=%b char_out=%h ca=%b required dones=1 busy=0 char_out=%h ca=0",
               done_cnt - d0, busy, char_out, char_available, last_c);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (char_available !== 1'b0 || char_out !== 7'h00 || busy !== 1'b0 || done !== 1'b0 ||
        len !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ca=%b co=%h busy=%b done=%b len=%0d ovf=%b required all 0",
               char_available, char_out, busy, done, len, overflow);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    int d0;
    wr(7'h3F); wr(7'h06);
    checks++;
    if (len !== 4'd2) begin
      errors++;
      $display("FAIL len_after_writes: got %0d required 2", len);
    end
    d0 = done_cnt;
    pulse_start();
    expect_issue(7'h3F, 0);
    expect_issue(7'h06, 0);
    check_done_end(7'h06, d0);
  endtask

  task automatic test_tick_modes();
    int d0;
    do_clear();
    wr(7'h7F); wr(7'h01);
    d0 = done_cnt;
    pulse_start();
    expect_issue(7'h7F, 1);
    expect_issue(7'h01, 2);
    check_done_end(7'h01, d0);
  endtask

  task automatic test_loop();
    logic [6:0] m [3];
    int d0;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      m[i] = 7'($urandom_range(0, 127));
      wr(m[i]);
    end
    loop = 1'b1;
    d0 = done_cnt;
    pulse_start();
    expect_issue(m[0], 0);
    expect_issue(m[1], 0);
    expect_issue(m[2], 0);
    expect_issue(m[0], 0);
    expect_issue(m[1], 0);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL loop_no_done: got %0d done pulses required 0", done_cnt - d0);
    end
    loop = 1'b0;
    expect_issue(m[2], 0);
    check_done_end(m[2], d0);
  endtask

  task automatic test_random();
    logic [6:0] q [$];
    int n, d0;
    for (int it = 0; it < 2; it++) begin
      do_clear();
      q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        q.push_back(7'($urandom_range(0, 127)));
        wr(q[i]);
      end
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < n; i++) expect_issue(q[i], 0);
      check_done_end(q[n-1], d0);
    end
  endtask

  task automatic test_overflow_clear();
    do_clear();
    for (int i = 0; i < 9; i++) wr(7'(i + 1));
    checks++;
    if (len !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow: len=%0d ovf=%b required len=8 ovf=1", len, overflow);
    end
    do_clear();
    checks++;
    if (len !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear: len=%0d ovf=%b required 0 0", len, overflow);
    end
    @(negedge clk); clear = 1'b1; wr_en = 1'b1; wr_data = 7'h55; start = 1'b1;
    @(negedge clk); clear = 1'b0; wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (len !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_with_write: len=%0d busy=%b required 0 0", len, busy);
    end
  endtask

  task automatic test_zero_dwell();
    int rises, highs, dones, bad_co;
    logic prev;
    logic [6:0] vals [3];
    vals[0] = 7'h00; vals[1] = 7'h00; vals[2] = 7'h7F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); z_wr_en = 1'b1; z_wr_data = vals[i];
    end
    @(negedge clk); z_wr_en = 1'b0;
    checks++;
    if (z_len !== 2'd2 || z_ovf !== 1'b1) begin
      errors++;
      $display("FAIL z_overflow: len=%0d ovf=%b required len=2 ovf=1", z_len, z_ovf);
    end
    z_start = 1'b1;
    @(negedge clk); z_start = 1'b0;
    rises = 0; highs = 0; dones = 0; bad_co = 0; prev = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (z_ca === 1'b1) begin
        highs++;
        if (!prev) rises++;
        if (z_co !== 7'h00) bad_co++;
      end
      if (z_done === 1'b1) dones++;
      prev = z_ca;
      @(negedge clk);
    end
    checks++;
    if (rises != 2 || highs != 2 || dones != 1 || bad_co != 0 || z_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_dwell: rises=%0d highs=%0d dones=%0d bad_chars=%0d busy=%b required 2 2 1 0 0",
               rises, highs, dones, bad_co, z_busy);
    end
    @(negedge clk); z_clear = 1'b1;
    @(negedge clk); z_clear = 1'b0;
    checks++;
    if (z_len !== 2'd0 || z_ovf !== 1'b0) begin
      errors++;
      $display("FAIL z_clear: len=%0d ovf=%b required 0 0", z_len, z_ovf);
    end
  endtask

  task automatic test_reset_mid_dwell();
    int w;
    do_clear();
    wr(7'h3F);
    pulse_start();
    w = 0;
    while (char_available !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    while (char_available === 1'b1 && w < 40) begin @(negedge clk); w++; end
    for (int k = 0; k < 3; k++) begin
      clk60 = 1'b1; @(negedge clk);
      clk60 = 1'b0; @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (char_available !== 1'b0 || char_out !== 7'h00 || busy !== 1'b0 || done !== 1'b0 ||
        len !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dwell: ca=%b co=%h busy=%b done=%b len=%0d ovf=%b required all 0",
               char_available, char_out, busy, done, len, overflow);
    end
    @(negedge clk); reset = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || char_available !== 1'b0) begin
      errors++;
      $display("FAIL start_empty: busy=%b ca=%b required 0 0", busy, char_available);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clk60 = 1'b0; wr_en = 1'b0; wr_data = '0;
    clear = 1'b0; start = 1'b0; loop = 1'b0;
    z_clk60 = 1'b0; z_wr_en = 1'b0; z_wr_data = '0; z_clear = 1'b0; z_start = 1'b0;
    test_reset();
    test_basic();
    test_tick_modes();
    test_loop();
    test_random();
    test_overflow_clear();
    test_zero_dwell();
    test_reset_mid_dwell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
